// File: rtl/m_unit_pkg.sv
// Shared types and constants for the execute-stage M-unit (multiplier/divider).
package m_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_t;

  function automatic logic div_op_is_signed(div_op_t op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic div_op_is_rem(div_op_t op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, trial-subtract
// the divisor, keep the difference when it does not borrow.
module div_step
  import m_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // One guard bit above the remainder makes the borrow of the trial subtract explicit.
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign diff    = shifted - {2'b00, divisor};

  always_comb begin
    rem_out = shifted[WIDTH:0];
    quo_out = {quo_in[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH+1]) begin
      rem_out = diff[WIDTH:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div32_iter.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |a| < |b|.
module div32_iter
  import m_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  div_op_t          op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output div_state_t       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid is never withdrawn by the producer except through kill or reset.

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q, div_q, result_q;
  logic             is_rem_q, neg_quo_q, neg_rem_q;

  logic             accept, is_signed, is_rem_in, a_neg, b_neg;
  logic             b_zero, ovf, early, take_short;
  logic [WIDTH-1:0] a_mag, b_mag, short_res, fix_res;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

  assign accept    = (state == IDLE) && in_valid && !kill;
  assign is_signed = div_op_is_signed(op);
  assign is_rem_in = div_op_is_rem(op);
  assign a_neg     = is_signed && operand_a[WIDTH-1];
  assign b_neg     = is_signed && operand_b[WIDTH-1];
  assign a_mag     = a_neg ? -operand_a : operand_a;
  assign b_mag     = b_neg ? -operand_b : operand_b;
  assign b_zero    = (operand_b == '0);
  assign ovf       = is_signed && (operand_a == MIN_NEG) && (operand_b == '1);

`ifdef DIV_EARLY_OUT_EN
  assign early = !b_zero && (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  assign take_short = b_zero || ovf || early;

  always_comb begin
    short_res = is_rem_in ? operand_a : '0;
    if (b_zero)   short_res = is_rem_in ? operand_a : '1;
    else if (ovf) short_res = is_rem_in ? '0 : MIN_NEG;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (div_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Sign fix-up is folded into the edge that enters DONE.
  always_comb begin
    if (is_rem_q) fix_res = neg_rem_q ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
    else          fix_res = neg_quo_q ? -step_quo : step_quo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = take_short ? DONE : CALC;
      CALC: begin
        if (kill)              state_nxt = IDLE;
        else if (count == '0)  state_nxt = DONE;
      end
      DONE: if (kill || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    result    = result_q;
    dbg_state = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      result_q  <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept) begin
      count     <= CW'(WIDTH-1);
      rem_q     <= '0;
      quo_q     <= a_mag;
      div_q     <= b_mag;
      is_rem_q  <= is_rem_in;
      neg_quo_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      if (take_short) result_q <= short_res;
    end else if ((state == CALC) && !kill) begin
      rem_q <= step_rem;
      quo_q <= step_quo;
      count <= count - 1'b1;
      if (count == '0) result_q <= fix_res;
    end
  end

endmodule
